// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared angle/turn format constants and sequencer state type
package cordic_pkg;

    // pi/2 in signed Q2.30 radians
    localparam logic signed [31:0] HALF_PI_Q2_30 = 32'sd1686629713;

    // Quarter and half turn of a 32-bit phase word, in the 33-bit signed fold domain
    localparam logic signed [32:0] QUARTER_TURN = 33'sd1073741824;
    localparam logic signed [32:0] HALF_TURN    = 33'sd2147483648;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCALE = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/cordic_sine_sequencer_if.sv
// rtl/cordic_sine_sequencer_if.sv - phase input, sine core and result handshake bundle
interface cordic_sine_sequencer_if #(
    parameter int BIT_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_WIDTH-1:0] in_phase;
    logic                 sine_start;
    logic [BIT_WIDTH-1:0] sine_angle;
    logic                 sine_ready;
    logic                 sine_done;
    logic [BIT_WIDTH-1:0] sine_value;
    logic                 result_valid;
    logic [BIT_WIDTH-1:0] result;
    logic                 busy;

    // Environment side: phase source and sine core
    modport master (
        output in_valid, in_phase, sine_ready, sine_done, sine_value,
        input  in_ready, sine_start, sine_angle, result_valid, result, busy
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_phase, sine_ready, sine_done, sine_value,
        output in_ready, sine_start, sine_angle, result_valid, result, busy
    );
endinterface

// File: rtl/cordic_phase_fold.sv
// rtl/cordic_phase_fold.sv - fold a full-turn phase into [-pi/2, pi/2] and scale to radians
module cordic_phase_fold #(
    parameter int                         BIT_WIDTH = 32,
    parameter logic signed [BIT_WIDTH-1:0] HALF_PI  = 32'sd1686629713
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic                        scale,
    input  logic [BIT_WIDTH-1:0]        phase,
    output logic signed [BIT_WIDTH-1:0] angle
);
    localparam logic signed [BIT_WIDTH:0] QUARTER = (BIT_WIDTH+1)'(1) <<< (BIT_WIDTH-2);
    localparam logic signed [BIT_WIDTH:0] HALF    = (BIT_WIDTH+1)'(1) <<< (BIT_WIDTH-1);

    logic signed [BIT_WIDTH:0]       s_wide;
    logic signed [BIT_WIDTH:0]       f_wide;
    logic signed [BIT_WIDTH-1:0]     folded_q;
    logic signed [2*BIT_WIDTH-1:0]   product;
    logic signed [2*BIT_WIDTH-1:0]   shifted;

    // Mirror phases beyond +/- a quarter turn back toward zero; sin(pi - x) = sin(x)
    always_comb begin
        s_wide = signed'({phase[BIT_WIDTH-1], phase});
        if (s_wide > QUARTER) begin
            f_wide = HALF - s_wide;
        end else if (s_wide < -QUARTER) begin
            f_wide = -HALF - s_wide;
        end else begin
            f_wide = s_wide;
        end
    end

    // Full-width signed product; arithmetic shift floors toward -inf
    assign product = folded_q * HALF_PI;
    assign shifted = product >>> (BIT_WIDTH-2);

    // Capture the folded phase on accept, then the scaled angle one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            folded_q <= '0;
            angle    <= '0;
        end else begin
            if (load) begin
                folded_q <= f_wide[BIT_WIDTH-1:0];
            end
            if (scale) begin
                angle <= shifted[BIT_WIDTH-1:0];
            end
        end
    end
endmodule

// File: rtl/cordic_sine_sequencer.sv
// rtl/cordic_sine_sequencer.sv - accept a phase, drive one sine core operation, return the sample
module cordic_sine_sequencer
    import cordic_pkg::*;
#(
    parameter int                         BIT_WIDTH = 32,
    parameter logic signed [BIT_WIDTH-1:0] HALF_PI  = HALF_PI_Q2_30
) (
    input logic                    clk,
    input logic                    reset,
    cordic_sine_sequencer_if.slave bus
);
    seq_state_t                  state;
    seq_state_t                  next_state;
    logic                        load;
    logic                        scale;
    logic                        issue;
    logic                        capture;
    logic                        start_q;
    logic                        result_valid_q;
    logic [BIT_WIDTH-1:0]        result_q;
    logic signed [BIT_WIDTH-1:0] angle;

    cordic_phase_fold #(
        .BIT_WIDTH (BIT_WIDTH),
        .HALF_PI   (HALF_PI)
    ) u_fold (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .scale (scale),
        .phase (bus.in_phase),
        .angle (angle)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and datapath strobes; done in the start cycle belongs to a previous operation
    always_comb begin
        next_state = state;
        load       = 1'b0;
        scale      = 1'b0;
        issue      = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    load       = 1'b1;
                    next_state = ST_SCALE;
                end
            end
            ST_SCALE: begin
                scale      = 1'b1;
                next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (bus.sine_ready) begin
                    issue      = 1'b1;
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.sine_done && !start_q) begin
                    capture    = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Registered start pulse, result capture and result valid pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q        <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
        end else begin
            start_q        <= issue;
            result_valid_q <= capture;
            if (capture) begin
                result_q <= bus.sine_value;
            end
        end
    end

    assign bus.in_ready     = (state == ST_IDLE);
    assign bus.busy         = (state != ST_IDLE);
    assign bus.sine_start   = start_q;
    assign bus.sine_angle   = angle;
    assign bus.result_valid = result_valid_q;
    assign bus.result       = result_q;
endmodule

// File: tb/tb_cordic_sine_sequencer.sv
// tb/tb_cordic_sine_sequencer.sv - directed vector bench for the sine sequencer
module tb_cordic_sine_sequencer;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    cordic_sine_sequencer_if #(.BIT_WIDTH(32)) bus ();

    cordic_sine_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]        phase;
        logic [31:0]        value;
        logic signed [31:0] angle;
        int                 stall;
        bit                 early_done;
    } vec_t;

    vec_t vecs[8];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int cycles;
        bit got;
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        bus.in_phase   = v.phase;
        bus.in_valid   = 1'b1;
        bus.sine_ready = (v.stall == 0);
        tick();
        bus.in_valid = 1'b0;
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 20 + v.stall) begin
            tick();
            cycles++;
            if (bus.sine_start) begin
                got = 1'b1;
            end else if (cycles >= 1) begin
                check("angle_stable", bus.sine_angle, v.angle);
                check("in_ready_low", 32'(bus.in_ready), 32'd0);
            end
            if (cycles == 1 + v.stall) bus.sine_ready = 1'b1;
        end
        check("start_latency", 32'(cycles), 32'(2 + v.stall));
        check("sine_angle", bus.sine_angle, v.angle);
        if (v.early_done) begin
            bus.sine_done  = 1'b1;
            bus.sine_value = 32'hDEAD_BEEF;
        end
        tick();
        bus.sine_done = 1'b0;
        check("start_one_cycle", 32'(bus.sine_start), 32'd0);
        if (v.early_done) check("early_done_ignored", 32'(bus.result_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = (v.stall > 0) && (k < 5);
            tick();
            check("wait_not_ready", 32'(bus.in_ready), 32'd0);
            check("wait_busy", 32'(bus.busy), 32'd1);
        end
        bus.in_valid   = 1'b0;
        bus.sine_done  = 1'b1;
        bus.sine_value = v.value;
        tick();
        bus.sine_done = 1'b0;
        check("result_valid", 32'(bus.result_valid), 32'd1);
        check("result", bus.result, v.value);
        check("ready_with_result", 32'(bus.in_ready), 32'd1);
        tick();
        check("result_valid_pulse", 32'(bus.result_valid), 32'd0);
        check("no_relaunch_busy", 32'(bus.busy), 32'd0);
        check("result_held", bus.result, v.value);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{32'h4000_0000, 32'h7FFF_FFF0,  32'sd1686629713, 0, 1'b0};
        vecs[1] = '{32'hC000_0000, 32'h8000_0010, -32'sd1686629713, 0, 1'b1};
        vecs[2] = '{32'h6000_0000, 32'h5A82_7999,  32'sd843314856,  0, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0000_0123,  32'sd0,          0, 1'b0};
        vecs[4] = '{32'h0000_0000, 32'hFFFF_FF00,  32'sd0,          5, 1'b0};
        vecs[5] = '{32'hA000_0000, 32'hA57D_8667, -32'sd843314857,  0, 1'b0};
        vecs[6] = '{32'h4000_0001, 32'h7FFF_FFFF,  32'sd1686629711, 0, 1'b0};
        vecs[7] = '{32'h2000_0000, 32'h1234_5678,  32'sd843314856,  0, 1'b0};

        bus.in_valid   = 1'b0;
        bus.in_phase   = '0;
        bus.sine_ready = 1'b1;
        bus.sine_done  = 1'b0;
        bus.sine_value = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_start", 32'(bus.sine_start), 32'd0);
        check("rst_angle", bus.sine_angle, 32'd0);
        check("rst_result_valid", 32'(bus.result_valid), 32'd0);
        check("rst_result", bus.result, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Reset while waiting on the sine core, then a stale done arrives
        bus.in_phase   = 32'h4000_0000;
        bus.in_valid   = 1'b1;
        bus.sine_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("abort_start", 32'(bus.sine_start), 32'd1);
        tick();
        check("abort_in_wait", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_result", bus.result, 32'd0);
        check("abort_angle", bus.sine_angle, 32'd0);
        check("abort_start_low", 32'(bus.sine_start), 32'd0);
        bus.sine_done  = 1'b1;
        bus.sine_value = 32'h7FFF_FFF0;
        tick();
        bus.sine_done = 1'b0;
        check("late_done_no_valid", 32'(bus.result_valid), 32'd0);
        tick();
        check("late_done_no_valid2", 32'(bus.result_valid), 32'd0);
        check("late_done_result", bus.result, 32'd0);
        check("late_done_idle", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/cordic_sine_sequencer.md
Name: cordic_sine_sequencer

Overview:
- Upstream feeder for the CORDIC sine wrapper.
- Accepts a full-circle phase word (unsigned fraction of one turn) through a valid/ready handshake.
- Folds the phase into the sine core's legal input range [-pi/2, pi/2]. Sine symmetry means no output negation is needed.
- Scales the folded phase to radians, issues one start to the sine core, waits for its done, and returns the captured result with a one-cycle valid pulse.

Parameters:
- BIT_WIDTH, 32: width of phase, angle and value. Do not exceed 32.
- HALF_PI, 32'sd1686629713: pi/2 in signed Q2.30.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  phase word present
- in_ready  out  1  block can accept a phase (high only in IDLE)
- in_phase  in  BIT_WIDTH  unsigned turns, 2^BIT_WIDTH = one full turn
- sine_start  out  1  one-cycle start pulse to the sine core
- sine_angle  out  BIT_WIDTH  signed Q2.30 radians, range [-HALF_PI, HALF_PI]
- sine_ready  in  1  sine core can accept a start
- sine_done  in  1  sine core result valid
- sine_value  in  BIT_WIDTH  sine core result, signed Q1.31
- result_valid  out  1  one-cycle pulse, result holds the new sample
- result  out  BIT_WIDTH  captured sine value
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - state = IDLE
  - in_ready = 1 from the first cycle after reset
  - sine_start = 0, sine_angle = 0
  - result_valid = 0, result = 0
  - busy = 0
- FSM states: IDLE -> SCALE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid at a clock edge: compute the fold combinationally from in_phase, register the folded value, go to SCALE.
- Fold arithmetic, in BIT_WIDTH+1 signed bits:
  - s = in_phase reinterpreted as signed turns in [-0.5, 0.5).
  - If s > 2^(BIT_WIDTH-2): f = 2^(BIT_WIDTH-1) - s.
  - Else if s < -2^(BIT_WIDTH-2): f = -2^(BIT_WIDTH-1) - s.
  - Else f = s.
  - Resulting f lies in [-2^(BIT_WIDTH-2), 2^(BIT_WIDTH-2)] and fits in BIT_WIDTH bits.
  - Edge case: s = -2^(BIT_WIDTH-1) folds to 0.
- SCALE:
  - sine_angle <= (f * HALF_PI) >>> (BIT_WIDTH-2).
  - Full 2*BIT_WIDTH-bit signed product; arithmetic shift truncates toward -inf; no rounding.
  - Go to ISSUE.
- ISSUE:
  - While sine_ready = 0: stay in ISSUE, sine_angle stable.
  - When sine_ready = 1: sine_start <= 1 for exactly one cycle, go to WAIT.
- WAIT:
  - sine_done is ignored in the cycle sine_start is high.
  - On a later sine_done = 1: result <= sine_value, result_valid <= 1 for one cycle, go to IDLE.
- sine_angle is held constant from the SCALE update until the next accepted phase.
- Latency from accept edge to sine_start high: 2 cycles, plus any sine_ready stall.
- in_valid outside IDLE is ignored (no accept, no queueing).
- result_valid and in_valid accept can coincide: result_valid pulses in the same cycle as in_ready returns to 1.
- Reset mid-operation, in any state:
  - Next state is IDLE, all outputs take their reset values.
  - No result_valid is produced for the aborted sample.
  - An in-flight sine core computation is discarded; the sine core is reset by the same reset.

Decomposition:
- Shared package cordic_pkg:
  - angle/turn format constants: HALF_PI_Q2_30, QUARTER_TURN, HALF_TURN
  - state enum typedef for the sequencer FSM
- One natural sub-module: cordic_phase_fold.
  - Combinational fold plus registered scale.
  - Reusable by a future cosine sequencer.

Test Plan:
- in_phase = 0x40000000 (quarter turn), sine_ready = 1 -> sine_angle = 1686629713, sine_start pulses 2 cycles after accept. Model done 10 cycles later with sine_value = 0x7FFFFFF0 -> result = 0x7FFFFFF0, result_valid one cycle.
- in_phase = 0xC0000000 -> sine_angle = -1686629713.
- in_phase = 0x60000000 (0.375 turn, folds to 0.125) -> sine_angle = 843314856.
- in_phase = 0x80000000 -> sine_angle = 0.
- in_phase = 0x00000000 -> sine_angle = 0.
- sine_ready held low 5 cycles in ISSUE -> no sine_start, sine_angle stable, in_ready = 0. Then sine_ready = 1 -> single sine_start pulse. in_valid asserted during WAIT -> not accepted.
- reset asserted in WAIT -> next cycle in_ready = 1, busy = 0, result = 0. A late sine_done produces no result_valid.
